// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and constants for the Simon game controller
//
// Holds the controller state encoding, button and LED codes, and the
// feedback mask of the pattern LFSR.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHOW_ON    = 3'd1,
        SHOW_OFF   = 3'd2,
        WAIT_INPUT = 3'd3,
        WIN        = 3'd4,
        LOSE       = 3'd5
    } state_t;

    // Pattern bit value for each button.
    localparam logic BTN_A = 1'b0;
    localparam logic BTN_B = 1'b1;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_BOTH = 2'b11;

    // Right-shifting Galois feedback mask.
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // LED code that lights the LED belonging to one pattern step.
    function automatic logic [1:0] step_led(input logic step);
        return (step == BTN_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// rtl/simon_lfsr.sv - free-running 32-bit Galois LFSR
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high; loads SEED
//   lfsr_o out  current LFSR value (advances every cycle out of reset)
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE11234
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - two-button Simon game controller
//
// Plays the stored sequence on the LEDs each round, then checks the player's
// presses against it. Captures a 32-step pattern from a free-running LFSR
// when a game starts.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high; returns to IDLE
//   start      in   pulse; starts a game from IDLE, WIN or LOSE
//   btn[1:0]   in   debounced press pulses (bit0 = A, bit1 = B)
//   led[1:0]   out  LED drive (bit0 = A, bit1 = B)
//   round_cnt  out  current / final round index
//   pos        out  position within the sequence
//   busy       out  playing back or waiting for input
//   win        out  game won
//   lose       out  game lost
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int          MAX_ROUNDS    = 16,
    parameter int          SHOW_TICKS    = 12500000,
    parameter int          GAP_TICKS     = 6250000,
    parameter int          TIMEOUT_TICKS = 100000000,
    parameter logic [31:0] SEED          = 32'hACE11234
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] btn,
    output logic [1:0] led,
    output logic [4:0] round_cnt,
    output logic [4:0] pos,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam logic [27:0] SHOW_LAST    = 28'(SHOW_TICKS - 1);
    localparam logic [27:0] GAP_LAST     = 28'(GAP_TICKS - 1);
    localparam logic [27:0] TIMEOUT_LAST = 28'(TIMEOUT_TICKS - 1);
    localparam logic [4:0]  LAST_ROUND   = 5'(MAX_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [27:0] timer_q, timer_d;
    logic [31:0] pattern_q, pattern_d;
    logic [4:0]  round_q, round_d;
    logic [4:0]  pos_q, pos_d;
    logic        round_clr, round_inc;
    logic        pos_clr, pos_inc;
    logic [1:0]  led_q, led_d;
    logic        busy_q, busy_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic [31:0] lfsr_value;
    logic        pressed;

    simon_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr_value)
    );

    // Only meaningful for a single press; btn == 11 is handled separately.
    assign pressed = btn[1] ? BTN_B : BTN_A;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        round_clr = 1'b0;
        round_inc = 1'b0;
        pos_clr   = 1'b0;
        pos_inc   = 1'b0;

        unique case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    pattern_d = lfsr_value;
                    round_clr = 1'b1;
                    pos_clr   = 1'b1;
                    state_d   = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (timer_q == SHOW_LAST) begin
                    state_d = SHOW_OFF;
                end else begin
                    timer_d = timer_q + 28'd1;
                end
            end
            SHOW_OFF: begin
                if (timer_q == GAP_LAST) begin
                    if (pos_q == round_q) begin
                        pos_clr = 1'b1;
                        state_d = WAIT_INPUT;
                    end else begin
                        pos_inc = 1'b1;
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + 28'd1;
                end
            end
            WAIT_INPUT: begin
                if (btn == 2'b00) begin
                    if (timer_q == TIMEOUT_LAST) begin
                        state_d = LOSE;
                    end else begin
                        timer_d = timer_q + 28'd1;
                    end
                end else if (btn == 2'b11) begin
                    state_d = LOSE;
                end else if (pressed != pattern_q[pos_q]) begin
                    state_d = LOSE;
                end else if (pos_q != round_q) begin
                    pos_inc = 1'b1;
                    timer_d = '0;
                end else if (round_q == LAST_ROUND) begin
                    state_d = WIN;
                end else begin
                    round_inc = 1'b1;
                    pos_clr   = 1'b1;
                    state_d   = SHOW_ON;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Clear takes precedence over increment.
        round_d = round_clr ? 5'd0 : (round_inc ? round_q + 5'd1 : round_q);
        pos_d   = pos_clr   ? 5'd0 : (pos_inc   ? pos_q + 5'd1   : pos_q);

        // Outputs are registered, so they are decoded from the next state.
        unique case (state_d)
            SHOW_ON:    led_d = step_led(pattern_d[pos_d]);
            // Mirror presses only once already waiting, so a pulse discarded
            // on the SHOW_OFF -> WAIT_INPUT edge never lights an LED.
            WAIT_INPUT: led_d = (state_q == WAIT_INPUT) ? btn : LED_OFF;
            WIN:        led_d = LED_BOTH;
            default:    led_d = LED_OFF;
        endcase
        busy_d = (state_d == SHOW_ON) || (state_d == SHOW_OFF) || (state_d == WAIT_INPUT);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pattern_q <= '0;
            round_q   <= '0;
            pos_q     <= '0;
            led_q     <= LED_OFF;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pattern_q <= pattern_d;
            round_q   <= round_d;
            pos_q     <= pos_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign led       = led_q;
    assign round_cnt = round_q;
    assign pos       = pos_q;
    assign busy      = busy_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - scoreboard testbench for simon_sequencer
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int MR = 3;
    localparam int ST = 2;
    localparam int GT = 1;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  btn = 2'b00;
    logic [1:0]  led;
    logic [4:0]  round_cnt;
    logic [4:0]  pos;
    logic        busy;
    logic        win;
    logic        lose;
    logic [31:0] model_q;
    logic [31:0] pat;

    always #5 clk = ~clk;

    simon_sequencer #(
        .MAX_ROUNDS    (MR),
        .SHOW_TICKS    (ST),
        .GAP_TICKS     (GT),
        .TIMEOUT_TICKS (TO),
        .SEED          (32'hACE11234)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .led       (led),
        .round_cnt (round_cnt),
        .pos       (pos),
        .busy      (busy),
        .win       (win),
        .lose      (lose)
    );

    simon_lfsr #(
        .SEED (32'hACE11234)
    ) u_model (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (model_q)
    );

    // Expected outputs right after the posedge that samples the inputs
    // driven together with the push: {led, round, pos, busy, win, lose}.
    typedef struct {
        logic [14:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [14:0] o(input logic [1:0] l, input int r, input int p,
                                      input logic b, input logic w, input logic ls);
        return {l, 5'(r), 5'(p), b, w, ls};
    endfunction

    function automatic logic [1:0] oh(input logic step);
        return step ? 2'b10 : 2'b01;
    endfunction

    task automatic cyc(input logic r, input logic s, input logic [1:0] b,
                       input logic [14:0] v, input string nm);
        exp_t e;
        @(negedge clk);
        reset = r;
        start = s;
        btn   = b;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // The pattern captured is the LFSR value seen at the sampling edge.
    task automatic start_game();
        exp_t e;
        @(negedge clk);
        pat   = model_q;
        reset = 1'b0;
        start = 1'b1;
        btn   = 2'b00;
        e.val  = o(oh(pat[0]), 0, 0, 1'b1, 1'b0, 1'b0);
        e.name = "start";
        sb.push_back(e);
    endtask

    // Entry into SHOW_ON pos 0 of round r has already been pushed.
    task automatic playback(input int r);
        for (int i = 0; i <= r; i++) begin
            if (i > 0) cyc(1'b0, 1'b0, 2'b00, o(oh(pat[i]), r, i, 1'b1, 1'b0, 1'b0), "show_on_entry");
            cyc(1'b0, 1'b0, oh(~pat[i]), o(oh(pat[i]), r, i, 1'b1, 1'b0, 1'b0), "show_on_hold");
            cyc(1'b0, 1'b1, 2'b00, o(LED_OFF, r, i, 1'b1, 1'b0, 1'b0), "show_off");
        end
        cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, r, 0, 1'b1, 1'b0, 1'b0), "wait_entry");
    endtask

    task automatic presses(input int r);
        for (int j = 0; j <= r; j++) begin
            cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, r, j, 1'b1, 1'b0, 1'b0), "wait_idle");
            if (j < r)
                cyc(1'b0, 1'b0, oh(pat[j]), o(oh(pat[j]), r, j + 1, 1'b1, 1'b0, 1'b0), "press_ok");
            else if (r == MR - 1)
                cyc(1'b0, 1'b0, oh(pat[j]), o(LED_BOTH, r, r, 1'b0, 1'b1, 1'b0), "press_win");
            else
                cyc(1'b0, 1'b0, oh(pat[j]), o(oh(pat[0]), r + 1, 0, 1'b1, 1'b0, 1'b0), "press_next_round");
        end
    endtask

    // Monitor: the DUT presents a registered output every cycle.
    initial begin
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {led, round_cnt, pos, busy, win, lose};
                n_checks++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: actual led=%b round=%0d pos=%0d busy=%b win=%b lose=%b, required led=%b round=%0d pos=%0d busy=%b win=%b lose=%b",
                             e.name, act[14:13], act[12:8], act[7:3], act[2], act[1], act[0],
                             e.val[14:13], e.val[12:8], e.val[7:3], e.val[2], e.val[1], e.val[0]);
                end
            end
        end
    end

    initial begin
        // Reset, with a start pulse that must be ignored.
        cyc(1'b1, 1'b0, 2'b00, '0, "reset0");
        cyc(1'b1, 1'b1, 2'b00, '0, "reset1");
        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b0, (k == 2) ? 2'b01 : 2'b00, '0, "idle");

        // Game 1: full win with ignored pulses during playback.
        start_game();
        for (int r = 0; r < MR; r++) begin
            playback(r);
            presses(r);
        end
        cyc(1'b0, 1'b0, 2'b00, o(LED_BOTH, 2, 2, 1'b0, 1'b1, 1'b0), "win_hold");

        // Game 2: wrong press in round 1, position 0.
        start_game();
        playback(0);
        presses(0);
        playback(1);
        cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, 1, 0, 1'b1, 1'b0, 1'b0), "wait_idle");
        cyc(1'b0, 1'b0, oh(~pat[0]), o(LED_OFF, 1, 0, 1'b0, 1'b0, 1'b1), "wrong_press");
        cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, 1, 0, 1'b0, 1'b0, 1'b1), "lose_hold");

        // Game 3: timeout after exactly TO cycles of waiting.
        start_game();
        playback(0);
        for (int k = 1; k < TO; k++)
            cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, 0, 0, 1'b1, 1'b0, 1'b0), "timeout_wait");
        cyc(1'b0, 1'b0, 2'b00, o(LED_OFF, 0, 0, 1'b0, 1'b0, 1'b1), "timeout_lose");

        // Game 4: both buttons at once.
        start_game();
        playback(0);
        cyc(1'b0, 1'b0, 2'b11, o(LED_OFF, 0, 0, 1'b0, 1'b0, 1'b1), "both_lose");

        // Game 5: reset during SHOW_ON of round 1.
        start_game();
        playback(0);
        presses(0);
        cyc(1'b1, 1'b1, 2'b00, '0, "reset_mid");
        cyc(1'b1, 1'b1, 2'b00, '0, "reset_hold");
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 2'b00, '0, "post_reset_idle");

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
